// File: rtl/vg64_bus_write_queue_if.sv
// Write-queue drain port between the vg64 cartridge front end and the SRAM slot sequencer.
interface vg64_bus_write_queue_if;
   logic        wr_valid;
   logic        wr_ready;
   logic        wr_bank;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;

   modport master (output wr_valid, output wr_bank, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_bank, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vg64_bus_write_queue.sv
// C64 IO1 register window for the vg64 framebuffer: decodes 6510 stores and queues
// {bank, addr, data} pixel writes in a first-word fall-through FIFO for the SRAM sequencer.
module vg64_bus_write_queue #(
   parameter logic [15:0] BASE  = 16'hDE00,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_64clk,
   input  logic                       i_64rw,
   input  logic [15:0]                i_64addr,
   input  logic [7:0]                 i_64data,
   output logic [7:0]                 token,
   vg64_bus_write_queue_if.master     wr,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef struct packed {
      logic        bank;
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   logic        phi_s1, phi_s2, rw_s1, rw_s2;
   logic [15:0] addr_s1, addr_s2;
   logic [7:0]  data_s1, data_s2;

   logic [15:0] ptr;
   logic [7:0]  step;

   wr_entry_t   mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [LW-1:0] count;

   logic        strobe_c;
   logic [15:0] offset_c;
   logic        token_we_c, ptr_lo_we_c, ptr_hi_we_c, data_we_c, step_we_c, ctrl_we_c;
   logic        valid_c, full_c, pop_c, push_c, drop_c, flush_c, clear_c;
   wr_entry_t   head_c;

   // Two-stage synchroniser for the asynchronous 6510 bus
   always_ff @(posedge clk) begin
      if (rst) begin
         phi_s1  <= 1'b0;
         phi_s2  <= 1'b0;
         rw_s1   <= 1'b1;
         rw_s2   <= 1'b1;
         addr_s1 <= '0;
         addr_s2 <= '0;
         data_s1 <= '0;
         data_s2 <= '0;
      end else begin
         phi_s1  <= i_64clk;
         phi_s2  <= phi_s1;
         rw_s1   <= i_64rw;
         rw_s2   <= rw_s1;
         addr_s1 <= i_64addr;
         addr_s2 <= addr_s1;
         data_s1 <= i_64data;
         data_s2 <= data_s1;
      end
   end

   // PHI2 falling edge; s2 still holds the address/data captured while PHI2 was high
   always_comb begin
      strobe_c    = ~phi_s1 & phi_s2 & ~rw_s2;
      offset_c    = addr_s2 - BASE;
      token_we_c  = strobe_c && (offset_c == 16'd0);
      ptr_lo_we_c = strobe_c && (offset_c == 16'd1);
      ptr_hi_we_c = strobe_c && (offset_c == 16'd2);
      data_we_c   = strobe_c && (offset_c == 16'd3);
      step_we_c   = strobe_c && (offset_c == 16'd4);
      ctrl_we_c   = strobe_c && (offset_c == 16'd5);
   end

   always_comb begin
      valid_c = (count != '0);
      full_c  = (count == LW'(DEPTH));
      pop_c   = valid_c && wr.wr_ready;
      push_c  = data_we_c && (!full_c || pop_c);
      drop_c  = data_we_c && full_c && !pop_c;
      flush_c = ctrl_we_c && data_s2[1];
      clear_c = ctrl_we_c && data_s2[0];
      head_c  = valid_c ? mem[head] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         token    <= 8'h00;
         ptr      <= 16'h0000;
         step     <= 8'h01;
         overflow <= 1'b0;
      end else begin
         if (token_we_c)  token     <= data_s2;
         if (ptr_lo_we_c) ptr[7:0]  <= data_s2;
         if (ptr_hi_we_c) ptr[15:8] <= data_s2;
         if (step_we_c)   step      <= data_s2;
         // Pointer advances on every data store, dropped or not
         if (data_we_c)   ptr       <= ptr + 16'(step);
         if (drop_c)
            overflow <= 1'b1;
         else if (clear_c)
            overflow <= 1'b0;
      end
   end

   // FIFO pointers; flush wins over any concurrent pop
   always_ff @(posedge clk) begin
      if (rst || flush_c) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push_c) tail <= tail + AW'(1);
         if (pop_c)  head <= head + AW'(1);
         if (push_c && !pop_c)
            count <= count + LW'(1);
         else if (pop_c && !push_c)
            count <= count - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[tail] <= '{bank: token[0], addr: ptr, data: data_s2};
   end

   assign wr.wr_valid = valid_c;
   assign wr.wr_bank  = head_c.bank;
   assign wr.wr_addr  = head_c.addr;
   assign wr.wr_data  = head_c.data;
   assign level       = count;

endmodule

// File: tb/tb_vg64_bus_write_queue.sv
// Bench for vg64_bus_write_queue: directed scenarios plus random CPU traffic checked
// every cycle against a queue-based model of the register window.
module tb_vg64_bus_write_queue;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;
   localparam logic [15:0] BASE  = 16'hDE00;

   typedef struct packed {
      logic        bank;
      logic [15:0] addr;
      logic [7:0]  data;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          phi = 1'b0;
   logic          rw = 1'b1;
   logic [15:0]   addr = 16'h0000;
   logic [7:0]    data = 8'h00;
   logic          ready = 1'b0;
   logic [7:0]    token;
   logic [LW-1:0] level;
   logic          overflow;

   vg64_bus_write_queue_if wr_if ();
   assign wr_if.wr_ready = ready;

   vg64_bus_write_queue #(.BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_64clk(phi), .i_64rw(rw), .i_64addr(addr), .i_64data(data),
      .token(token), .wr(wr_if), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model state
   ent_t        mq[$];
   logic [7:0]  m_token = 8'h00;
   logic [7:0]  m_step = 8'h01;
   logic [15:0] m_ptr = 16'h0000;
   logic        m_ov = 1'b0;
   logic [15:0] cw_addr = 16'h0000;
   logic [7:0]  cw_data = 8'h00;
   bit          rand_ready = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // One clk cycle: apply the model for this edge, then compare the DUT at the falling edge
   task automatic tick(input bit strobe);
      logic [15:0] off;
      bit          pop, accept;
      ent_t        exp_e, got_e;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_token = 8'h00; m_ptr = 16'h0000; m_step = 8'h01; m_ov = 1'b0;
      end else begin
         off    = cw_addr - BASE;
         pop    = ready && (mq.size() > 0);
         accept = (mq.size() < DEPTH) || pop;
         if (strobe && off == 16'd5 && cw_data[1]) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (strobe && off == 16'd3) begin
               if (accept) mq.push_back('{bank: m_token[0], addr: m_ptr, data: cw_data});
               else m_ov = 1'b1;
               m_ptr = m_ptr + {8'h00, m_step};
            end
         end
         if (strobe) begin
            case (off)
               16'd0: m_token = cw_data;
               16'd1: m_ptr[7:0] = cw_data;
               16'd2: m_ptr[15:8] = cw_data;
               16'd4: m_step = cw_data;
               16'd5: if (cw_data[0]) m_ov = 1'b0;
               default: ;
            endcase
         end
      end
      @(negedge clk);
      exp_e = (mq.size() > 0) ? mq[0] : '0;
      got_e = {wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data};
      checks += 6;
      if (wr_if.wr_valid !== (mq.size() > 0)) begin
         errors++; $display("FAIL cyc_valid t=%0t: got %b exp %b", $time, wr_if.wr_valid, mq.size() > 0);
      end
      if (level !== LW'(mq.size())) begin
         errors++; $display("FAIL cyc_level t=%0t: got %0d exp %0d", $time, level, mq.size());
      end
      if (overflow !== m_ov) begin
         errors++; $display("FAIL cyc_overflow t=%0t: got %b exp %b", $time, overflow, m_ov);
      end
      if (token !== m_token) begin
         errors++; $display("FAIL cyc_token t=%0t: got %h exp %h", $time, token, m_token);
      end
      if (dut.ptr !== m_ptr || dut.step !== m_step) begin
         errors++; $display("FAIL cyc_ptr_step t=%0t: got %h/%h exp %h/%h", $time, dut.ptr, dut.step, m_ptr, m_step);
      end
      if (got_e !== exp_e) begin
         errors++; $display("FAIL cyc_head t=%0t: got %h exp %h", $time, got_e, exp_e);
      end
      if (rand_ready) ready = 1'($urandom_range(0, 1));
   endtask

   // One 6510 bus cycle; optionally raise wr_ready exactly in the strobe cycle
   task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input bit is_read, input bit pop_at_strobe);
      cw_addr = a; cw_data = d;
      addr = a; data = d; rw = is_read; phi = 1'b1;
      repeat (3) tick(1'b0);
      phi = 1'b0;
      tick(1'b0);
      if (pop_at_strobe) ready = 1'b1;
      tick(!is_read);
      if (pop_at_strobe) ready = 1'b0;
      tick(1'b0);
      rw = 1'b1;
      tick(1'b0);
   endtask

   task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
      cpu_cycle(BASE + 16'(off), d, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick(1'b0);
      rst = 1'b0;
      tick(1'b0);
      checks++;
      if (token !== 8'h00 || level !== '0 || wr_if.wr_valid !== 1'b0 || overflow !== 1'b0 || dut.step !== 8'h01) begin
         errors++;
         $display("FAIL reset: token=%h level=%0d valid=%b ovf=%b step=%h", token, level, wr_if.wr_valid, overflow, dut.step);
      end
   endtask

   task automatic test_single_write();
      ready = 1'b0;
      wr_reg(3'd0, 8'h01);
      wr_reg(3'd1, 8'h34);
      wr_reg(3'd2, 8'h12);
      wr_reg(3'd3, 8'hAA);
      checks++;
      if (wr_if.wr_valid !== 1'b1 || {wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data} !== {1'b1, 16'h1234, 8'hAA} || level !== LW'(1)) begin
         errors++;
         $display("FAIL single_write: valid=%b entry=%b/%h/%h level=%0d exp 1/1234/aa 1",
                  wr_if.wr_valid, wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data, level);
      end
      ready = 1'b1;
      tick(1'b0);
      ready = 1'b0;
      checks++;
      if (level !== '0 || wr_if.wr_valid !== 1'b0) begin
         errors++; $display("FAIL single_pop: level=%0d valid=%b exp 0 0", level, wr_if.wr_valid);
      end
   endtask

   task automatic test_autoinc_wrap();
      ready = 1'b0;
      wr_reg(3'd5, 8'h02);
      wr_reg(3'd0, 8'h00);
      wr_reg(3'd4, 8'h03);
      wr_reg(3'd1, 8'hFE);
      wr_reg(3'd2, 8'hFF);
      wr_reg(3'd3, 8'h11);
      wr_reg(3'd3, 8'h22);
      checks++;
      if ({wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data} !== {1'b0, 16'hFFFE, 8'h11} || level !== LW'(2)) begin
         errors++; $display("FAIL wrap_first: entry=%b/%h/%h level=%0d exp 0/fffe/11 2",
                            wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data, level);
      end
      ready = 1'b1;
      tick(1'b0);
      ready = 1'b0;
      checks++;
      if ({wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data} !== {1'b0, 16'h0001, 8'h22}) begin
         errors++; $display("FAIL wrap_second: entry=%b/%h/%h exp 0/0001/22", wr_if.wr_bank, wr_if.wr_addr, wr_if.wr_data);
      end
      ready = 1'b1;
      tick(1'b0);
      ready = 1'b0;
   endtask

   task automatic test_overflow();
      ready = 1'b0;
      wr_reg(3'd4, 8'h05);
      wr_reg(3'd1, 8'h00);
      wr_reg(3'd2, 8'h01);
      for (int i = 0; i < DEPTH + 2; i++) wr_reg(3'd3, 8'h40 + 8'(i));
      checks++;
      if (level !== LW'(DEPTH) || overflow !== 1'b1 || wr_if.wr_addr !== 16'h0100 || wr_if.wr_data !== 8'h40) begin
         errors++; $display("FAIL overflow: level=%0d ovf=%b head=%h/%h exp %0d 1 0100/40",
                            level, overflow, wr_if.wr_addr, wr_if.wr_data, DEPTH);
      end
      checks++;
      if (dut.ptr !== 16'(16'h0100 + (DEPTH + 2) * 5)) begin
         errors++; $display("FAIL overflow_ptr: got %h exp %h", dut.ptr, 16'(16'h0100 + (DEPTH + 2) * 5));
      end
      wr_reg(3'd5, 8'h01);
      checks++;
      if (overflow !== 1'b0 || level !== LW'(DEPTH)) begin
         errors++; $display("FAIL overflow_clear: ovf=%b level=%0d exp 0 %0d", overflow, level, DEPTH);
      end
   endtask

   task automatic test_full_pop();
      cpu_cycle(BASE + 16'd3, 8'hEE, 1'b0, 1'b1);
      checks++;
      if (level !== LW'(DEPTH) || overflow !== 1'b0 || wr_if.wr_data !== 8'h41) begin
         errors++; $display("FAIL full_pop: level=%0d ovf=%b head=%h exp %0d 0 41", level, overflow, wr_if.wr_data, DEPTH);
      end
   endtask

   task automatic test_flush_reset();
      ready = 1'b0;
      wr_reg(3'd5, 8'h02);
      wr_reg(3'd0, 8'h81);
      for (int i = 0; i < 5; i++) wr_reg(3'd3, 8'(i));
      checks++;
      if (level !== LW'(5)) begin
         errors++; $display("FAIL flush_pre: level=%0d exp 5", level);
      end
      wr_reg(3'd5, 8'h02);
      checks++;
      if (level !== '0 || wr_if.wr_valid !== 1'b0) begin
         errors++; $display("FAIL flush: level=%0d valid=%b exp 0 0", level, wr_if.wr_valid);
      end
      for (int i = 0; i < 3; i++) wr_reg(3'd3, 8'hC0 + 8'(i));
      ready = 1'b1;
      rst = 1'b1;
      tick(1'b0);
      checks++;
      if (wr_if.wr_valid !== 1'b0 || level !== '0) begin
         errors++; $display("FAIL reset_mid: valid=%b level=%0d exp 0 0", wr_if.wr_valid, level);
      end
      tick(1'b0);
      rst = 1'b0;
      tick(1'b0);
      ready = 1'b0;
      checks++;
      if (level !== '0 || token !== 8'h00) begin
         errors++; $display("FAIL reset_after: level=%0d token=%h exp 0 00", level, token);
      end
   endtask

   task automatic test_random();
      logic [15:0] a;
      logic [7:0]  d;
      int          off;
      bit          rd;
      rand_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         off = ($urandom_range(0, 9) < 4) ? 3 : int'($urandom_range(0, 7));
         d   = 8'($urandom);
         if (off == 5) d = 8'($urandom_range(0, 3));
         if (off == 4) d = 8'($urandom_range(0, 4));
         a   = (off == 7) ? BASE - 16'd1 : BASE + 16'(off);
         rd  = ($urandom_range(0, 7) == 0);
         cpu_cycle(a, d, rd, 1'b0);
      end
      rand_ready = 1'b0;
      ready = 1'b1;
      repeat (DEPTH + 2) tick(1'b0);
      ready = 1'b0;
      checks++;
      if (level !== '0 || wr_if.wr_valid !== 1'b0) begin
         errors++; $display("FAIL random_drain: level=%0d valid=%b exp 0 0", level, wr_if.wr_valid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_autoinc_wrap();
      test_overflow();
      test_full_pop();
      test_flush_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
